// File: rtl/ysyx_22041071_rf_bypass.sv
// Register file plus operand bypass stage feeding EX through a valid/ready slot.
// Optional YSYX_22041071_RF_DEBUG_EN exposes the whole array on dbg_regs for difftest.

module ysyx_22041071_rf_bypass_rdport #(
  parameter int XLEN = 64,
  parameter int NFWD = 3
) (
  input  logic [4:0]           addr_i,
  input  logic [XLEN-1:0]      arr_i,
  input  logic [NFWD-1:0]      fwd_en_i,
  input  logic [NFWD*5-1:0]    fwd_addr_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 wb_en_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [XLEN-1:0]      data_o
);
  // Walk oldest to youngest so the lowest matching source ends up winning.
  always_comb begin
    data_o = arr_i;
    if (wb_en_i && wb_addr_i == addr_i) data_o = wb_data_i;
    for (int k = NFWD-1; k >= 0; k--) begin
      if (fwd_en_i[k] && fwd_addr_i[5*k +: 5] == addr_i && fwd_addr_i[5*k +: 5] != 5'd0)
        data_o = fwd_data_i[XLEN*k +: XLEN];
    end
    if (addr_i == 5'd0) data_o = '0;
  end
endmodule

module ysyx_22041071_rf_bypass #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3,
  parameter int PW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [NRD*5-1:0]     rd_addr,
  input  logic [NRD-1:0]       rd_use,
  input  logic [PW-1:0]        payload_in,
  input  logic [NFWD-1:0]      fwd_en,
  input  logic [NFWD*5-1:0]    fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 fwd_is_load,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 valid_out,
  input  logic                 ready_in,
`ifdef YSYX_22041071_RF_DEBUG_EN
  output logic [NREG*XLEN-1:0] dbg_regs,
`endif
  output logic [NRD*XLEN-1:0]  rd_data_q,
  output logic [PW-1:0]        payload_q
);
  logic [XLEN-1:0]           regs_q [NREG];
  logic [NRD-1:0][XLEN-1:0]  rd_data_d;
  logic                      valid_q;
  logic                      hit;
  logic                      stall;
  logic                      slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    ysyx_22041071_rf_bypass_rdport #(.XLEN(XLEN), .NFWD(NFWD)) u_rd (
      .addr_i     (rd_addr[5*i +: 5]),
      .arr_i      (regs_q[rd_addr[5*i +: 5]]),
      .fwd_en_i   (fwd_en),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .wb_en_i    (wb_en),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (wb_data),
      .data_o     (rd_data_d[i])
    );
  end

  // Load in EX whose result a consumed operand needs: hold upstream one cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NRD; i++)
      if (rd_use[i] && rd_addr[5*i +: 5] == fwd_addr[4:0]) hit = 1'b1;
  end

  assign stall     = valid_in && fwd_is_load && fwd_en[0] && fwd_addr[4:0] != 5'd0 && hit;
  assign slot_free = !valid_q || ready_in;
  assign ready_out = slot_free && !stall;
  assign valid_out = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rd_data_q <= '0;
      payload_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (slot_free) begin
      if (stall) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_in;
        if (valid_in) begin
          rd_data_q <= rd_data_d;
          payload_q <= payload_in;
        end
      end
    end
  end

`ifdef YSYX_22041071_RF_DEBUG_EN
  for (genvar r = 0; r < NREG; r++) begin : g_dbg
    assign dbg_regs[XLEN*r +: XLEN] = regs_q[r];
  end
`endif
endmodule

// File: tb/tb_ysyx_22041071_rf_bypass.sv
// Directed stimulus with a FIFO scoreboard; a negedge monitor checks every valid output slot.

module tb_ysyx_22041071_rf_bypass;
  logic          clk = 1'b0;
  logic          reset, valid_in, ready_out, fwd_is_load, wb_en, flush, valid_out, ready_in;
  logic [9:0]    rd_addr;
  logic [1:0]    rd_use;
  logic [63:0]   payload_in, payload_q, wb_data;
  logic [2:0]    fwd_en;
  logic [14:0]   fwd_addr;
  logic [191:0]  fwd_data;
  logic [4:0]    wb_addr;
  logic [127:0]  rd_data_q;
`ifdef YSYX_22041071_RF_DEBUG_EN
  logic [2047:0] dbg_regs;
`endif

  typedef struct packed { logic [127:0] d; logic [63:0] p; } exp_t;
  exp_t sb[$];
  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  ysyx_22041071_rf_bypass dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .rd_addr(rd_addr), .rd_use(rd_use), .payload_in(payload_in),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .valid_out(valid_out), .ready_in(ready_in),
`ifdef YSYX_22041071_RF_DEBUG_EN
    .dbg_regs(dbg_regs),
`endif
    .rd_data_q(rd_data_q), .payload_q(payload_q)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] p1, input logic [63:0] p0, input logic [63:0] pl);
    exp_t e;
    e.d = {p1, p0};
    e.p = pl;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {127'd0, valid_out}, 128'd0);
      end else begin
        chk("slot_data", rd_data_q, sb[0].d);
        chk("slot_payload", {64'd0, payload_q}, {64'd0, sb[0].p});
        if (ready_in) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; valid_in = 1'b1; rd_addr = {5'd5, 5'd0}; rd_use = 2'b11;
    payload_in = 64'h100; fwd_en = '0; fwd_addr = '0; fwd_data = '0; fwd_is_load = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; ready_in = 1'b1;
    tick();
    chk("reset_valid", {127'd0, valid_out}, 128'd0);
    chk("reset_data", rd_data_q, 128'd0);
    chk("reset_payload", {64'd0, payload_q}, 128'd0);

    // first instruction after reset reads zeros
    reset = 1'b0;
    push(64'd0, 64'd0, 64'h100); tick();

    // write-through, then array read, then write to x0
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h1234; rd_addr = {5'd0, 5'd7}; payload_in = 64'h101;
    push(64'd0, 64'h1234, 64'h101); tick();
    wb_en = 1'b0; rd_addr = {5'd7, 5'd7}; payload_in = 64'h102;
    push(64'h1234, 64'h1234, 64'h102); tick();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hFF; rd_addr = {5'd7, 5'd0}; payload_in = 64'h103;
    push(64'h1234, 64'd0, 64'h103); tick();

    // forwarding priority over write-through and array
    fwd_en = 3'b111; fwd_addr = {5'd9, 5'd9, 5'd9};
    fwd_data = {64'hCCCC, 64'hBBBB, 64'hAAAA};
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'hDDDD; rd_addr = {5'd7, 5'd9}; payload_in = 64'h104;
    push(64'h1234, 64'hAAAA, 64'h104); tick();
    wb_en = 1'b0; fwd_en = 3'b110; payload_in = 64'h105;
    push(64'h1234, 64'hBBBB, 64'h105); tick();
    fwd_en = 3'b100; payload_in = 64'h106;
    push(64'h1234, 64'hCCCC, 64'h106); tick();
    fwd_en = 3'b000; payload_in = 64'h107;
    push(64'h1234, 64'hDDDD, 64'h107); tick();

    // load-use hazard: one bubble, data then arrives on source 1
    fwd_is_load = 1'b1; fwd_en = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd3};
    fwd_data = {64'd0, 64'd0, 64'hDEAD}; rd_addr = {5'd3, 5'd7}; rd_use = 2'b10; payload_in = 64'h108;
    #1 chk("loaduse_ready", {127'd0, ready_out}, 128'd0);
    tick();
    chk("loaduse_bubble", {127'd0, valid_out}, 128'd0);
    fwd_is_load = 1'b0; fwd_en = 3'b010; fwd_addr = {5'd0, 5'd3, 5'd0};
    fwd_data = {64'd0, 64'h55, 64'd0};
    #1 chk("after_stall_ready", {127'd0, ready_out}, 128'd1);
    push(64'h55, 64'h1234, 64'h108); tick();

    // same hazard, operand not consumed: no stall
    fwd_is_load = 1'b1; fwd_en = 3'b001; fwd_addr = {5'd0, 5'd0, 5'd3};
    fwd_data = {64'd0, 64'd0, 64'h77}; rd_use = 2'b00; payload_in = 64'h109;
    #1 chk("nouse_ready", {127'd0, ready_out}, 128'd1);
    push(64'h77, 64'h1234, 64'h109); tick();
    fwd_is_load = 1'b0; fwd_en = 3'b000; rd_use = 2'b11;

    // back-pressure: X held for three cycles while inputs change
    rd_addr = {5'd7, 5'd9}; payload_in = 64'h200;
    push(64'h1234, 64'hDDDD, 64'h200); tick();
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_addr = {5'd3, 5'(i + 1)}; payload_in = 64'h300 + 64'(i);
      #1 chk("bp_ready", {127'd0, ready_out}, 128'd0);
      tick();
    end
    ready_in = 1'b1; rd_addr = {5'd0, 5'd12}; payload_in = 64'h400;
    push(64'd0, 64'd0, 64'h400); tick();

    // flush with EX stalled; the register write that cycle still commits
    ready_in = 1'b0; flush = 1'b1; rd_addr = {5'd0, 5'd7}; payload_in = 64'h500;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 64'hABC;
    tick();
    chk("flush_valid", {127'd0, valid_out}, 128'd0);
    void'(sb.pop_front());
    flush = 1'b0; wb_en = 1'b0; ready_in = 1'b1; rd_addr = {5'd0, 5'd12}; payload_in = 64'h600;
    push(64'd0, 64'hABC, 64'h600); tick();

    // flush with EX ready: accepted upstream but dropped
    flush = 1'b1; rd_addr = {5'd0, 5'd9}; payload_in = 64'h700;
    #1 chk("flush_handshake", {127'd0, ready_out}, 128'd1);
    tick();
    chk("flush_drop", {127'd0, valid_out}, 128'd0);
    flush = 1'b0;

    // reset with a held slot and a pending write
    rd_addr = {5'd7, 5'd9}; payload_in = 64'h800;
    push(64'h1234, 64'hDDDD, 64'h800); tick();
    ready_in = 1'b0; reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h999;
    tick();
    chk("midreset_valid", {127'd0, valid_out}, 128'd0);
    chk("midreset_data", rd_data_q, 128'd0);
    void'(sb.pop_front());
    reset = 1'b0; wb_en = 1'b0; ready_in = 1'b1; rd_addr = {5'd7, 5'd9}; payload_in = 64'h900;
    push(64'd0, 64'd0, 64'h900); tick();
    rd_addr = {5'd0, 5'd12}; payload_in = 64'h901;
    push(64'd0, 64'd0, 64'h901); tick();

    valid_in = 1'b0;
    repeat (4) tick();
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22041071_rf_bypass.md
# ysyx_22041071_rf_bypass

Parametrised register-file and operand-bypass stage for the ysyx_22041071 pipelined core, the successor to the fixed 2-read/3-source decode datapath. It holds the architectural integer registers and provides NRD read ports with priority forwarding from NFWD later pipeline stages plus WB write-through. It detects load-use hazards and registers the resolved operands and a sideband payload into a valid/ready output slot feeding EX.

## Interface
- XLEN, 64, register and data width
- NREG, 32, number of architectural registers; index 0 is hard-wired zero
- NRD, 2, number of read ports
- NFWD, 3, number of forwarding sources; index 0 = EX (youngest), NFWD-1 = oldest
- PW, 64, width of the sideband payload carried with the operands (PC, control bits)

- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  upstream decode slot valid
- ready_out  out  1  stage can accept upstream
- rd_addr  in  NRD*5  read addresses, port i at [5i+4:5i]
- rd_use  in  NRD  port i operand actually consumed by the instruction
- payload_in  in  PW  sideband, registered unchanged
- fwd_en  in  NFWD  source k writes a register
- fwd_addr  in  NFWD*5  destination of source k
- fwd_data  in  NFWD*XLEN  result of source k
- fwd_is_load  in  1  source 0 is a load (data not yet available)
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  XLEN  write data
- flush  in  1  discard output slot (branch/jump redirect)
- valid_out  out  1  output slot valid
- ready_in  in  1  EX can accept
- rd_data_q  out  NRD*XLEN  registered operands
- payload_q  out  PW  registered sideband

## Operation
- Read value, port i, priority high to low: rd_addr==0 -> 0; lowest k with fwd_en[k] && fwd_addr[k]==rd_addr && fwd_addr[k]!=0 -> fwd_data[k]; wb_en && wb_addr==rd_addr -> wb_data (write-through); else array contents.
- Write: on clk edge, if wb_en && wb_addr!=0 and not reset, array[wb_addr] <= wb_data. Independent of stall, flush, handshake. Writes to 0 ignored.
- stall = valid_in && fwd_is_load && fwd_en[0] && fwd_addr[0]!=0 && any i with rd_use[i] && rd_addr[i]==fwd_addr[0].
- slot_free = !valid_out || ready_in.
- ready_out = slot_free && !stall (combinational).
- Output update priority: reset > flush > slot_free.
  - flush: valid_out <= 0; data regs hold.
  - slot_free && stall: valid_out <= 0 (bubble), data regs hold.
  - slot_free && !stall: valid_out <= valid_in; rd_data_q/payload_q <= resolved operands/payload_in when valid_in.
  - !slot_free: all output regs hold (EX back-pressure).
- Reset: valid_out=0, rd_data_q=0, payload_q=0, all NREG registers=0.

## Timing
- Latency 1 cycle: accepted instruction appears on valid_out the next edge.
- Full throughput: one instruction per cycle while ready_in=1 and no stall.
- Load-use: exactly one bubble per hazard; next cycle the load has left source 0 and its data arrives via source 1 forwarding.
- Forward and write data used combinationally in the accept cycle; no registered path from fwd_data.
- flush coincident with valid_in: upstream is still handshaked if ready_out=1, but the instruction is dropped; upstream must also squash.
- Reset in mid-stall or with valid_out=1 and ready_in=0: all state cleared that edge; wb write suppressed.

## Configuration
- YSYX_22041071_RF_DEBUG_EN defined: adds output dbg_regs (NREG*XLEN), register r at [XLEN*r+XLEN-1:XLEN*r], reflecting array contents after each edge (r=0 reads 0), for difftest.
- Not defined: port absent; no other behaviour change.

## Test plan
- Reset then read: reset=1 one cycle, valid_in=1, rd_addr={5,0}, ready_in=1 -> next cycle valid_out=1, rd_data_q={0,0}.
- Write/read-through: wb_en=1, wb_addr=7, wb_data=0x1234, same cycle rd_addr[0]=7 -> rd_data_q[0]=0x1234; wb_addr=0 write of 0xFF -> x0 still reads 0.
- Forward priority: fwd_en=3'b111, all fwd_addr=9, data {A,B,C} for k=0..2, rd_addr=9 -> rd_data_q=A; clear fwd_en[0] -> B.
- Load-use: fwd_is_load=1, fwd_addr[0]=3, rd_addr[1]=3, rd_use=2'b10 -> ready_out=0, one valid_out=0 cycle; same with rd_use=2'b00 -> no stall.
- Back-pressure: valid_out=1, ready_in=0 for 3 cycles with changing inputs -> rd_data_q/payload_q unchanged, ready_out=0; ready_in=1 -> new instruction accepted.
- Flush: valid_out=1, flush=1 -> next cycle valid_out=0 regardless of ready_in; register writes that cycle still committed.
